// File: rtl/tlb_memtype_ctrl.sv
// Memory-type range table shared by the data-TLB and code-TLB paths.
// Two requesters are arbitrated round-robin; attributes are returned one cycle after accept.
module tlb_memtype_ctrl #(
    parameter int NUM_RANGES = 4,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_physical,
    output logic             req0_ready,
    output logic             resp0_valid,
    output logic             resp0_cache_disable,
    output logic             resp0_write_transparent,
    input  logic             req1_valid,
    input  logic [31:0]      req1_physical,
    output logic             req1_ready,
    output logic             resp1_valid,
    output logic             resp1_cache_disable,
    output logic             resp1_write_transparent,
    input  logic             cfg_write,
    input  logic [IDX_W-1:0] cfg_index,
    input  logic [27:0]      cfg_base,
    input  logic [27:0]      cfg_limit,
    input  logic             cfg_enable,
    input  logic             cfg_cd,
    input  logic             cfg_wt,
    output logic             cfg_done
);

    localparam logic [27:0] VGA_BASE  = 28'h000A000;
    localparam logic [27:0] VGA_LIMIT = 28'h000C000;

    logic [27:0]           base_q  [NUM_RANGES];
    logic [27:0]           limit_q [NUM_RANGES];
    logic [NUM_RANGES-1:0] en_q;
    logic [NUM_RANGES-1:0] cd_q;
    logic [NUM_RANGES-1:0] wt_q;

    // rr_last = 1 means requester 1 was granted most recently.
    logic rr_last;
    logic acc0, acc1;
    logic [27:0] lookup_phys;
    logic hit_cd, hit_wt;

    logic vld0_p1, vld1_p1;
    logic cd0_p1, wt0_p1, cd1_p1, wt1_p1;
    logic cfg_done_p1;

    logic unused_low_bits;
    assign unused_low_bits = ^{req0_physical[3:0], req1_physical[3:0]};

    // Stage 0: arbitration and table lookup in the accept cycle
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && !cfg_write) begin
            req0_ready = req0_valid && (!req1_valid || rr_last);
            req1_ready = req1_valid && (!req0_valid || !rr_last);
        end
    end

    assign acc0        = req0_valid && req0_ready;
    assign acc1        = req1_valid && req1_ready;
    assign lookup_phys = acc1 ? req1_physical[31:4] : req0_physical[31:4];

    // Walk from the top index down so the lowest matching entry is applied last.
    always_comb begin
        hit_cd = 1'b0;
        hit_wt = 1'b0;
        for (int i = NUM_RANGES - 1; i >= 0; i--) begin
            if (en_q[i] && (lookup_phys >= base_q[i]) && (lookup_phys < limit_q[i])) begin
                hit_cd = cd_q[i];
                hit_wt = wt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RANGES; i++) begin
                base_q[i]  <= (i == 0) ? VGA_BASE  : 28'h0;
                limit_q[i] <= (i == 0) ? VGA_LIMIT : 28'h0;
                en_q[i]    <= (i == 0);
                cd_q[i]    <= (i == 0);
                wt_q[i]    <= (i == 0);
            end
        end else if (cfg_write) begin
            // Indices beyond the table match no entry and leave it untouched.
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (cfg_index == IDX_W'(i)) begin
                    base_q[i]  <= cfg_base;
                    limit_q[i] <= cfg_limit;
                    en_q[i]    <= cfg_enable;
                    cd_q[i]    <= cfg_cd;
                    wt_q[i]    <= cfg_wt;
                end
            end
        end
    end

    // Stage 1: registered responses and config acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last     <= 1'b1;
            vld0_p1     <= 1'b0;
            vld1_p1     <= 1'b0;
            cd0_p1      <= 1'b0;
            wt0_p1      <= 1'b0;
            cd1_p1      <= 1'b0;
            wt1_p1      <= 1'b0;
            cfg_done_p1 <= 1'b0;
        end else begin
            vld0_p1     <= acc0;
            vld1_p1     <= acc1;
            cfg_done_p1 <= cfg_write;
            if (acc0) begin
                cd0_p1  <= hit_cd;
                wt0_p1  <= hit_wt;
                rr_last <= 1'b0;
            end
            if (acc1) begin
                cd1_p1  <= hit_cd;
                wt1_p1  <= hit_wt;
                rr_last <= 1'b1;
            end
        end
    end

    // A response still in flight when reset arrives is suppressed.
    assign resp0_valid             = vld0_p1 && !rst;
    assign resp1_valid             = vld1_p1 && !rst;
    assign resp0_cache_disable     = cd0_p1;
    assign resp0_write_transparent = wt0_p1;
    assign resp1_cache_disable     = cd1_p1;
    assign resp1_write_transparent = wt1_p1;
    assign cfg_done                = cfg_done_p1;

endmodule

// File: tb/tb_tlb_memtype_ctrl.sv
// Bench for tlb_memtype_ctrl: directed vector tables, multi-cycle corner sequences,
// and randomized traffic against a first-match range model.
module tb_tlb_memtype_ctrl;

    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_physical, req1_physical;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp0_cache_disable, resp0_write_transparent;
    logic        resp1_valid, resp1_cache_disable, resp1_write_transparent;
    logic        cfg_write;
    logic [1:0]  cfg_index;
    logic [27:0] cfg_base, cfg_limit;
    logic        cfg_enable, cfg_cd, cfg_wt;
    logic        cfg_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlb_memtype_ctrl #(.NUM_RANGES(NR), .IDX_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_physical(req0_physical), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_cache_disable(resp0_cache_disable),
        .resp0_write_transparent(resp0_write_transparent),
        .req1_valid(req1_valid), .req1_physical(req1_physical), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_cache_disable(resp1_cache_disable),
        .resp1_write_transparent(resp1_write_transparent),
        .cfg_write(cfg_write), .cfg_index(cfg_index), .cfg_base(cfg_base),
        .cfg_limit(cfg_limit), .cfg_enable(cfg_enable), .cfg_cd(cfg_cd), .cfg_wt(cfg_wt),
        .cfg_done(cfg_done)
    );

    typedef struct {
        logic [31:0] phys;
        logic        cd;
        logic        wt;
    } vec_t;

    vec_t t1[4];
    vec_t t4[3];
    int   grant_seq[4];

    // Reference table
    logic [27:0] mb [NR];
    logic [27:0] ml [NR];
    logic        men[NR];
    logic        mcd[NR];
    logic        mwt[NR];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cfg_write = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] idx, input logic [27:0] b, input logic [27:0] l,
                          input logic en, input logic cd, input logic wt, input string nm);
        cfg_write = 1'b1;
        cfg_index = idx;
        cfg_base = b;
        cfg_limit = l;
        cfg_enable = en;
        cfg_cd = cd;
        cfg_wt = wt;
        step();
        cfg_write = 1'b0;
        chk1({nm, "_done"}, cfg_done, 1'b1);
    endtask

    task automatic look(input int ch, input logic [31:0] p, input logic ecd, input logic ewt,
                        input string nm);
        if (ch == 0) begin
            req0_valid = 1'b1;
            req0_physical = p;
        end else begin
            req1_valid = 1'b1;
            req1_physical = p;
        end
        #1;
        chk1({nm, "_ready"}, (ch == 0) ? req0_ready : req1_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (ch == 0) begin
            chk1({nm, "_valid"}, resp0_valid, 1'b1);
            chk1({nm, "_cd"}, resp0_cache_disable, ecd);
            chk1({nm, "_wt"}, resp0_write_transparent, ewt);
        end else begin
            chk1({nm, "_valid"}, resp1_valid, 1'b1);
            chk1({nm, "_cd"}, resp1_cache_disable, ecd);
            chk1({nm, "_wt"}, resp1_write_transparent, ewt);
        end
    endtask

    function automatic logic [1:0] model_lookup(input logic [31:0] p);
        for (int i = 0; i < NR; i++) begin
            if (men[i] && p[31:4] >= mb[i] && p[31:4] < ml[i]) return {mcd[i], mwt[i]};
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_phys();
        logic [27:0] hi;
        case ($urandom_range(0, 2))
            0:       hi = 28'h0009FF0 + 28'($urandom_range(0, 'h2030));
            1:       hi = 28'($urandom_range(0, 63));
            default: hi = 28'($urandom);
        endcase
        return {hi, 4'($urandom)};
    endfunction

    initial begin
        t1[0] = '{32'h000A0000, 1'b1, 1'b1};
        t1[1] = '{32'h000BFFFF, 1'b1, 1'b1};
        t1[2] = '{32'h000C0000, 1'b0, 1'b0};
        t1[3] = '{32'h0009FFF0, 1'b0, 1'b0};
        t4[0] = '{32'h000B8000, 1'b1, 1'b1};
        t4[1] = '{32'h000C8000, 1'b0, 1'b0};
        t4[2] = '{32'h000D0000, 1'b0, 1'b0};
        grant_seq = '{0, 1, 0, 1};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_physical = '0; req1_physical = '0;
        cfg_write = 1'b0; cfg_index = '0; cfg_base = '0; cfg_limit = '0;
        cfg_enable = 1'b0; cfg_cd = 1'b0; cfg_wt = 1'b0;

        // Reset state, with a request held to show ready is blocked
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        step();
        chk1("rst_resp0_valid", resp0_valid, 1'b0);
        chk1("rst_resp1_valid", resp1_valid, 1'b0);
        chk1("rst_cfg_done", cfg_done, 1'b0);
        chk1("rst_cd0", resp0_cache_disable, 1'b0);
        chk1("rst_wt0", resp0_write_transparent, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;

        // Back-to-back lookups around the VGA window
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_physical = t1[i].phys;
            #1;
            chk1($sformatf("t1_%0d_ready", i), req0_ready, 1'b1);
            step();
            chk1($sformatf("t1_%0d_valid", i), resp0_valid, 1'b1);
            chk1($sformatf("t1_%0d_cd", i), resp0_cache_disable, t1[i].cd);
            chk1($sformatf("t1_%0d_wt", i), resp0_write_transparent, t1[i].wt);
        end
        req0_valid = 1'b0;
        req0_physical = 32'h000A0000;
        step();
        chk1("t1_pulse_end", resp0_valid, 1'b0);
        chk1("t1_hold_cd", resp0_cache_disable, 1'b0);

        // Round-robin with both requesters held
        do_reset();
        req0_valid = 1'b1; req0_physical = 32'h000A0000;
        req1_valid = 1'b1; req1_physical = 32'h000E8000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1($sformatf("rr_%0d_ready0", i), req0_ready, grant_seq[i] == 0);
            chk1($sformatf("rr_%0d_ready1", i), req1_ready, grant_seq[i] == 1);
            step();
            chk1($sformatf("rr_%0d_resp0", i), resp0_valid, grant_seq[i] == 0);
            chk1($sformatf("rr_%0d_resp1", i), resp1_valid, grant_seq[i] == 1);
            if (grant_seq[i] == 0) chk1($sformatf("rr_%0d_cd0", i), resp0_cache_disable, 1'b1);
            else                   chk1($sformatf("rr_%0d_cd1", i), resp1_cache_disable, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Config write stalls a pending request for one cycle
        req0_valid = 1'b1; req0_physical = 32'h000E8000;
        cfg_write = 1'b1; cfg_index = 2'd1; cfg_base = 28'h000E000; cfg_limit = 28'h000F000;
        cfg_enable = 1'b1; cfg_cd = 1'b1; cfg_wt = 1'b0;
        #1;
        chk1("t3_stall_ready0", req0_ready, 1'b0);
        step();
        cfg_write = 1'b0;
        chk1("t3_done", cfg_done, 1'b1);
        chk1("t3_no_resp", resp0_valid, 1'b0);
        #1;
        chk1("t3_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        chk1("t3_valid", resp0_valid, 1'b1);
        chk1("t3_cd", resp0_cache_disable, 1'b1);
        chk1("t3_wt", resp0_write_transparent, 1'b0);
        chk1("t3_done_pulse", cfg_done, 1'b0);

        // Overlapping ranges: lowest index wins
        cfg_wr(2'd1, 28'h000B000, 28'h000D000, 1'b1, 1'b0, 1'b0, "t4_cfg");
        for (int i = 0; i < 3; i++)
            look(0, t4[i].phys, t4[i].cd, t4[i].wt, $sformatf("t4_%0d", i));

        // Inverted range never matches; out-of-range index leaves the table alone
        cfg_wr(2'd2, 28'h000F000, 28'h000E000, 1'b1, 1'b1, 1'b1, "t5_inv");
        look(1, 32'h000E8000, 1'b0, 1'b0, "t5_inv_look");
        cfg_wr(2'd3, 28'h0000000, 28'hFFFFFFF, 1'b1, 1'b1, 1'b1, "t5_oob");
        look(0, 32'h000E8000, 1'b0, 1'b0, "t5_oob_look");
        step();
        chk1("t5_done_clear", cfg_done, 1'b0);

        // Reset drops an in-flight response and a simultaneous config write
        cfg_wr(2'd1, 28'h000E000, 28'h000F000, 1'b1, 1'b1, 1'b1, "t6_cfg");
        look(0, 32'h000E8000, 1'b1, 1'b1, "t6_pre");
        req1_valid = 1'b1; req1_physical = 32'h000E8000;
        #1;
        chk1("t6_ready1", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        rst = 1'b1;
        cfg_write = 1'b1; cfg_index = 2'd2; cfg_base = 28'h0; cfg_limit = 28'hFFFFFFF;
        cfg_enable = 1'b1; cfg_cd = 1'b1; cfg_wt = 1'b1;
        #1;
        chk1("t6_dropped", resp1_valid, 1'b0);
        step();
        cfg_write = 1'b0;
        rst = 1'b0;
        chk1("t6_done_cleared", cfg_done, 1'b0);
        look(1, 32'h000E8000, 1'b0, 1'b0, "t6_restored");
        look(1, 32'h000A0000, 1'b1, 1'b1, "t6_vga");

        // Randomized traffic against the reference model
        begin
            logic        v0, v1, g0, g1, cw, rr;
            logic [31:0] p0, p1;
            logic [1:0]  a0, a1, r;
            logic        ev0, ev1;
            logic [1:0]  widx;
            logic [27:0] wb, wl;
            logic        wen, wcd, wwt;

            do_reset();
            for (int i = 0; i < NR; i++) begin
                mb[i] = (i == 0) ? 28'h000A000 : 28'h0;
                ml[i] = (i == 0) ? 28'h000C000 : 28'h0;
                men[i] = (i == 0); mcd[i] = (i == 0); mwt[i] = (i == 0);
            end
            rr = 1'b1;
            v0 = 1'b0; v1 = 1'b0; p0 = '0; p1 = '0;
            a0 = 2'b00; a1 = 2'b00;

            for (int c = 0; c < 400; c++) begin
                if (!v0 && $urandom_range(0, 2) != 0) begin v0 = 1'b1; p0 = rand_phys(); end
                if (!v1 && $urandom_range(0, 2) != 0) begin v1 = 1'b1; p1 = rand_phys(); end
                cw   = ($urandom_range(0, 7) == 0);
                widx = 2'($urandom_range(0, 3));
                wb   = 28'($urandom_range(0, 63));
                wl   = 28'($urandom_range(0, 63));
                wen  = 1'($urandom); wcd = 1'($urandom); wwt = 1'($urandom);

                req0_valid = v0; req0_physical = p0;
                req1_valid = v1; req1_physical = p1;
                cfg_write = cw; cfg_index = widx; cfg_base = wb; cfg_limit = wl;
                cfg_enable = wen; cfg_cd = wcd; cfg_wt = wwt;
                #1;

                // Round-robin: with both pending, the one not granted last time wins.
                g0 = 1'b0; g1 = 1'b0;
                if (!cw) begin
                    if (v0 && v1) begin
                        if (rr) g0 = 1'b1; else g1 = 1'b1;
                    end else begin
                        g0 = v0; g1 = v1;
                    end
                end
                chk1($sformatf("rnd%0d_ready0", c), req0_ready, g0);
                chk1($sformatf("rnd%0d_ready1", c), req1_ready, g1);
                ev0 = g0; ev1 = g1;
                if (g0) a0 = model_lookup(p0);
                if (g1) a1 = model_lookup(p1);

                step();
                chk1($sformatf("rnd%0d_v0", c), resp0_valid, ev0);
                chk1($sformatf("rnd%0d_v1", c), resp1_valid, ev1);
                r = {resp0_cache_disable, resp0_write_transparent};
                chk1($sformatf("rnd%0d_cd0", c), r[1], a0[1]);
                chk1($sformatf("rnd%0d_wt0", c), r[0], a0[0]);
                r = {resp1_cache_disable, resp1_write_transparent};
                chk1($sformatf("rnd%0d_cd1", c), r[1], a1[1]);
                chk1($sformatf("rnd%0d_wt1", c), r[0], a1[0]);
                chk1($sformatf("rnd%0d_done", c), cfg_done, cw);

                if (cw && int'(widx) < NR) begin
                    mb[widx] = wb; ml[widx] = wl;
                    men[widx] = wen; mcd[widx] = wcd; mwt[widx] = wwt;
                end
                if (g0) begin v0 = 1'b0; rr = 1'b0; end
                if (g1) begin v1 = 1'b0; rr = 1'b1; end
            end
            cfg_write = 1'b0;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
